// File: rtl/mux_pkg.sv
// Shared types for the 4:1 mux select path.
// Channel count, select width and arbiter state.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: ptr has top priority.
// Rotate, fixed-priority pick, un-rotate.
module rr_pick_4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              gnt_vld,
  output sel_t              gnt_idx
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  sel_t                off;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_CH-1:0];

  // Lowest set bit of the rotated request wins
  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]:  off = sel_t'(0);
      rot[1]:  off = sel_t'(1);
      rot[2]:  off = sel_t'(2);
      rot[3]:  off = sel_t'(3);
      default: off = '0;
    endcase
  end

  assign gnt_vld = |req;
  assign gnt_idx = off + ptr;

endmodule

// File: rtl/rr_sel_arbiter_4.sv
// Four-channel round-robin arbiter feeding the 4:1 mux select.
// RR_SEL_ARBITER_STATS_EN adds per-channel grant counters.
module rr_sel_arbiter_4
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]     in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output sel_t                  out_sel,
  input  logic                  out_ready
`ifdef RR_SEL_ARBITER_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]  grant_cnt
`endif
);

  state_t           state;
  sel_t             ptr;
  logic             gnt_vld;
  sel_t             gnt_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] ch [NUM_CH];

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Split the flat input bus into per-channel words
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign out_valid = (state == FULL);
  assign load      = ~out_valid | out_ready;
  assign xfer      = load & gnt_vld & ~rst;

  // Acknowledge only the granted channel
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register, state and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (xfer) begin
      state    <= FULL;
      out_data <= ch[gnt_idx];
      out_sel  <= gnt_idx;
      ptr      <= gnt_idx + sel_t'(1);
    end else if (out_ready) begin
      state    <= EMPTY;
    end
  end

`ifdef RR_SEL_ARBITER_STATS_EN
  logic [15:0] cnt [NUM_CH];

  // Saturating per-channel transfer counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (xfer && gnt_idx == sel_t'(i) && cnt[i] != 16'hFFFF) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Pack counters onto the flat port
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_cnt[i*16 +: 16] = cnt[i];
    end
  end
`endif

endmodule
